// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory word, RAM handshake state, arbiter state.
// Imported by the memory arbiter and its bench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Instruction/data memory arbiter: one RAM port shared by I$ and D$.
// Optional starvation guard for the I$ enabled by MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;

  logic dreq;
  logic ramdone;
  logic dcomplete;
  logic icomplete;

  assign dreq      = dREN | dWEN;
  assign ramdone   = (ramstate == ACCESS);
  assign dcomplete = (state_q == DGRANT) & dreq & ramdone;
  assign icomplete = (state_q == IGRANT) & iREN & ramdone;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CLOG = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = (CLOG > 3) ? CLOG : 3;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  assign starved = (cnt_q == LIMIT) & iREN;

  // Count data completions that overtook a waiting instruction fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (icomplete) begin
      cnt_d = '0;
    end else if ((state_q == IDLE) & ~iREN) begin
      cnt_d = '0;
    end else if (dcomplete & iREN & (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic starved;
  logic unused_cfg;

  assign starved    = 1'b0;
  assign unused_cfg = (STARVE_LIMIT > 0);
`endif

  // Next-state: data wins in IDLE unless the fetch has starved.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (starved) begin
          state_d = IGRANT;
        end else if (dreq) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        if (~iREN | ramdone) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (~dreq | ramdone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any grant in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM request side and stall outputs decoded from the grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    if (!RST) begin
      unique case (state_q)
        IGRANT: begin
          ramaddr = iaddr;
          ramREN  = iREN;
          iwait   = ~ramdone;
        end
        DGRANT: begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dwait    = ~ramdone;
        end
        default: begin
          ramREN = 1'b0;
        end
      endcase
    end
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then
// random traffic against a grant-ownership reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  // reference model: who owns the RAM port, starvation tally
  int m_own;  // 0 none, 1 instruction, 2 data
  int m_cnt;

  task automatic model_check(input string pfx);
    logic e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = '0; e_store = '0;
    if (m_own == 1) begin
      e_addr = iaddr;
      e_ren  = iREN;
      e_iw   = (ramstate != ACCESS);
    end else if (m_own == 2) begin
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_dw    = (ramstate != ACCESS);
    end
    chk({pfx, ".ramREN"}, 32'(ramREN), 32'(e_ren));
    chk({pfx, ".ramWEN"}, 32'(ramWEN), 32'(e_wen));
    chk({pfx, ".ramaddr"}, ramaddr, e_addr);
    chk({pfx, ".ramstore"}, ramstore, e_store);
    chk({pfx, ".iwait"}, 32'(iwait), 32'(e_iw));
    chk({pfx, ".dwait"}, 32'(dwait), 32'(e_dw));
    chk({pfx, ".iload"}, iload, ramload);
    chk({pfx, ".dload"}, dload, ramload);
  endtask

  task automatic model_step();
    bit acc;
    acc = (ramstate == ACCESS);
    if (m_own == 0) begin
      if (!iREN) m_cnt = 0;
      if (FAIR && m_cnt == LIM && iREN) m_own = 1;
      else if (dREN || dWEN) m_own = 2;
      else if (iREN) m_own = 1;
    end else if (m_own == 1) begin
      if (!iREN) m_own = 0;
      else if (acc) begin
        m_own = 0;
        m_cnt = 0;
      end
    end else begin
      if (!(dREN || dWEN)) m_own = 0;
      else if (acc) begin
        m_own = 0;
        if (iREN && m_cnt < LIM) m_cnt++;
      end
    end
  endtask

  initial begin
    int dcomp, icomp, dfirst;
    idle_inputs();
    RST = 1;
    #12;
    chk("rst.ramREN", 32'(ramREN), 0);
    chk("rst.ramWEN", 32'(ramWEN), 0);
    chk("rst.iwait", 32'(iwait), 1);
    chk("rst.dwait", 32'(dwait), 1);
    chk("rst.ramaddr", ramaddr, 0);
    chk("rst.ramstore", ramstore, 0);

    // instruction read with BUSY, BUSY, ACCESS
    cyc();
    RST = 0;
    iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    #1;
    chk("ird.idle.ramREN", 32'(ramREN), 0);
    chk("ird.idle.iwait", 32'(iwait), 1);
    cyc();
    #1;
    chk("ird.g.ramREN", 32'(ramREN), 1);
    chk("ird.g.ramaddr", ramaddr, 32'h40);
    chk("ird.busy1.iwait", 32'(iwait), 1);
    cyc();
    #1;
    chk("ird.busy2.iwait", 32'(iwait), 1);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    chk("ird.acc.iwait", 32'(iwait), 0);
    chk("ird.acc.iload", iload, 32'hDEADBEEF);
    chk("ird.acc.dwait", 32'(dwait), 1);
    cyc();
    ramstate = FREE;
    #1;
    chk("ird.after.idle", 32'(ramREN), 0);
    chk("ird.after.iwait", 32'(iwait), 1);
    iREN = 0;

    // simultaneous I and D: data first, one IDLE gap, then I
    cyc();
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h80;
    cyc();
    #1;
    chk("both.d.ramaddr", ramaddr, 32'h80);
    chk("both.d.ramREN", 32'(ramREN), 1);
    chk("both.d.iwait", 32'(iwait), 1);
    ramstate = ACCESS;
    #1;
    chk("both.d.dwait", 32'(dwait), 0);
    cyc();
    ramstate = FREE; dREN = 0;
    #1;
    chk("both.gap.ramREN", 32'(ramREN), 0);
    cyc();
    #1;
    chk("both.i.ramaddr", ramaddr, 32'h44);
    chk("both.i.ramREN", 32'(ramREN), 1);
    ramstate = ACCESS;
    cyc();
    idle_inputs();

    // write wins over read; ERROR retries until ACCESS
    cyc();
    dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'h1234;
    cyc();
    ramstate = ERROR;
    #1;
    chk("wr.ramWEN", 32'(ramWEN), 1);
    chk("wr.ramREN", 32'(ramREN), 0);
    chk("wr.ramstore", ramstore, 32'h1234);
    chk("wr.err1.dwait", 32'(dwait), 1);
    cyc();
    #1;
    chk("wr.err2.ramWEN", 32'(ramWEN), 1);
    chk("wr.err2.dwait", 32'(dwait), 1);
    ramstate = ACCESS;
    #1;
    chk("wr.acc.dwait", 32'(dwait), 0);
    cyc();
    idle_inputs();

    // data request withdrawn while BUSY
    cyc();
    dREN = 1; daddr = 32'hC;
    cyc();
    ramstate = BUSY;
    #1;
    chk("wd.busy.dwait", 32'(dwait), 1);
    dREN = 0;
    #1;
    chk("wd.drop.dwait", 32'(dwait), 1);
    cyc();
    dREN = 1;
    #1;
    chk("wd.idle.ramREN", 32'(ramREN), 0);
    chk("wd.idle.dwait", 32'(dwait), 1);
    cyc();
    #1;
    chk("wd.regrant.ramREN", 32'(ramREN), 1);
    dREN = 0;
    cyc();

    // reset in the middle of a data write grant
    dWEN = 1; daddr = 32'h20; dstore = 32'h55;
    cyc();
    ramstate = BUSY;
    #1;
    chk("mr.pre.ramWEN", 32'(ramWEN), 1);
    RST = 1;
    #1;
    chk("mr.rst.ramWEN", 32'(ramWEN), 0);
    chk("mr.rst.dwait", 32'(dwait), 1);
    chk("mr.rst.ramaddr", ramaddr, 0);
    cyc();
    RST = 0;
    #1;
    chk("mr.rel.idle", 32'(ramWEN), 0);
    idle_inputs();
    cyc();

    // I and D held high with RAM always ready
    iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200;
    ramstate = ACCESS;
    dcomp = 0; icomp = 0; dfirst = -1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (!dwait) dcomp++;
      if (!iwait) begin
        if (icomp == 0) dfirst = dcomp;
        icomp++;
      end
      cyc();
    end
    if (FAIR) chk("fair.d_before_i", 32'(dfirst), 32'(LIM));
    else chk("strict.igrants", 32'(icomp), 0);
    idle_inputs();

    // random traffic against the model
    RST = 1;
    cyc();
    RST = 0;
    m_own = 0; m_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      iREN = ($urandom_range(0, 3) != 0);
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      #1;
      model_check("rnd");
      model_step();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the max consecutive data grants while an instruction request waits (fairness build only).
REQ-002 Port CLK  in  1  system clock, all state on rising edge.
REQ-003 Port RST  in  1  reset, asynchronous, active-high.
REQ-004 Ports iREN in 1, iaddr in 32: instruction-cache read request and word address.
REQ-005 Ports iwait out 1, iload out 32: instruction stall and read data.
REQ-006 Ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32: data-cache read/write request, address, write data.
REQ-007 Ports dwait out 1, dload out 32: data stall and read data.
REQ-008 Ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32: RAM request side.
REQ-009 Ports ramload in 32, ramstate in ramstate_t (FREE, BUSY, ACCESS, ERROR): RAM response side.

Function
REQ-010 FSM states IDLE, IGRANT, DGRANT; state register only, all outputs combinational from state and inputs.
REQ-011 IDLE: ramREN=ramWEN=0, iwait=dwait=1; next = DGRANT if dREN|dWEN, else IGRANT if iREN, else IDLE.
REQ-012 Data beats instruction when both are pending in IDLE (except per REQ-022).
REQ-013 DGRANT: ramaddr=daddr, ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both asserted).
REQ-014 IGRANT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-015 Granted requester's wait = 0 exactly in cycles where ramstate==ACCESS; other requester's wait = 1 always.
REQ-016 ACCESS in grant state: completion; next state IDLE; one IDLE cycle always separates consecutive grants.
REQ-017 BUSY/FREE in grant state: stay, wait held 1.
REQ-018 ERROR in grant state: stay, wait held 1, request reissued unchanged (retry until ACCESS).
REQ-019 Granted requester deasserts its enables before ACCESS: next state IDLE, no completion counted.
REQ-020 iload=ramload and dload=ramload unconditionally.

Reset
REQ-021 RST asserted (any time, incl. mid-grant): state=IDLE and fairness counter=0 immediately; outputs ramREN=ramWEN=0, iwait=dwait=1, ramaddr=ramstore=0 while RST held.

Configuration
REQ-022 With MEM_ARB_FAIRNESS_EN defined: 3-bit-min counter incremented on each data completion (DGRANT+ACCESS) while iREN=1, saturating at STARVE_LIMIT; in IDLE with counter==STARVE_LIMIT and iREN=1, next=IGRANT regardless of data request; counter cleared on instruction completion or when iREN=0 in IDLE.
REQ-023 Without MEM_ARB_FAIRNESS_EN: no counter, strict data priority per REQ-011/012.

Structure
REQ-024 ramstate_t, word_t and arb_state_t (IDLE, IGRANT, DGRANT) live in cpu_types_pkg; STARVE_LIMIT stays a module parameter.
REQ-025 No sub-module; single flat block.

Verification
REQ-026 Reset mid-DGRANT with ramstate=BUSY -> same cycle ramWEN=0, dwait=1; after release, state IDLE.
REQ-027 iREN=1, iaddr=0x40, ramstate goes BUSY,BUSY,ACCESS with ramload=0xDEADBEEF -> IGRANT next cycle, iwait=0 and iload=0xDEADBEEF only in ACCESS cycle, then IDLE.
REQ-028 iREN and dREN asserted together, daddr=0x80 -> DGRANT first, ramaddr=0x80; after ACCESS, one IDLE cycle, then IGRANT.
REQ-029 dREN=dWEN=1, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234; ramstate=ERROR twice then ACCESS -> dwait low only on ACCESS.
REQ-030 Fairness build, STARVE_LIMIT=4, iREN and dREN held high -> exactly 4 data completions, then IGRANT; without macro, zero instruction grants while dREN held.
REQ-031 dREN dropped while DGRANT and ramstate=BUSY -> IDLE next cycle, dwait stays 1, counter unchanged.
